// File: rtl/bcd_interval_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_interval_ctrl_if
//  Description : Command / status bundle between the controller and the
//                logic that drives it (commands in, BCD count and flags out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_interval_ctrl_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  mode;
  logic [4*DIGITS-1:0]   target;
  logic                  tick;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  done;
  logic                  err;

  // Control side: issues commands, observes status
  modport master (
    output start, stop, clear, mode, target, tick,
    input  count, running, done, err
  );

  // Controller side: accepts commands, reports status
  modport slave (
    input  start, stop, clear, mode, target, tick,
    output count, running, done, err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_interval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_interval_ctrl
//  Description : Run/pause/terminal-count sequencer for a cascade of BCD
//                digit counters, with one-shot and auto-reload completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_interval_ctrl #(
  parameter int DIGITS = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  bcd_interval_ctrl_if.slave   bus
);

  localparam int C_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [C_W-1:0]   r_count, w_count_nxt;
  logic [C_W-1:0]   r_target, w_target_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic [C_W-1:0]   w_count_inc;
  logic             w_target_ok;
  logic             w_terminal;

  // BCD increment of the current count, carry rippling through every digit
  always_comb begin
    logic       v_carry;
    logic [3:0] v_dig;
    w_count_inc = r_count;
    v_carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      v_dig = r_count[4*d +: 4];
      if (v_carry) begin
        if (v_dig == 4'd9) begin
          w_count_inc[4*d +: 4] = 4'd0;
        end else begin
          w_count_inc[4*d +: 4] = v_dig + 4'd1;
          v_carry               = 1'b0;
        end
      end
    end
  end

  // Incoming target is usable only if every nibble is a decimal digit and it is nonzero
  always_comb begin
    w_target_ok = (bus.target != '0);
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.target[4*d +: 4] > 4'd9) begin
        w_target_ok = 1'b0;
      end
    end
  end

  // Since count never passes the target, "count == target-1" is the same as
  // "count+1 == target", which reuses the incrementer instead of a decrementer.
  assign w_terminal = (w_count_inc == r_target);

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_target <= '0;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_target <= w_target_nxt;
      r_mode   <= w_mode_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next-state and next-output decode; clear > stop > start > tick
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_target_nxt = r_target;
    w_mode_nxt   = r_mode;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;

    if (bus.clear) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A rejected start leaves the current state and count untouched
          if (bus.start) begin
            if (w_target_ok) begin
              w_state_nxt  = S_RUN;
              w_count_nxt  = '0;
              w_target_nxt = bus.target;
              w_mode_nxt   = bus.mode;
              w_err_nxt    = 1'b0;
            end else begin
              w_err_nxt    = 1'b1;
            end
          end
        end

        S_RUN: begin
          if (bus.stop) begin
            w_state_nxt = S_PAUSE;
          end else if (bus.tick) begin
            if (w_terminal) begin
              w_done_nxt = 1'b1;
              if (r_mode) begin
                w_count_nxt = '0;
              end else begin
                w_count_nxt = r_target;
                w_state_nxt = S_DONE;
              end
            end else begin
              w_count_nxt = w_count_inc;
            end
          end
        end

        S_PAUSE: begin
          if (bus.start) begin
            w_state_nxt = S_RUN;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.count   = r_count;
  assign bus.running = (r_state == S_RUN);
  assign bus.done    = r_done;
  assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_interval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_interval_ctrl
//  Description : Directed stimulus with a per-cycle expected-status queue;
//                a monitor compares DUT status against the queue each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_interval_ctrl;

  logic clk;
  logic rst_n;

  bcd_interval_ctrl_if #(.DIGITS(2)) bus ();

  bcd_interval_ctrl #(.DIGITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {count[7:0], running, done, err}
  typedef logic [10:0] exp_t;
  exp_t q_exp[$];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) << 4 | (v % 10));
  endfunction

  // Monitor: one expected entry per cycle, checked just after the edge
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        a = {bus.count, bus.running, bus.done, bus.err};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL status: actual count=%h run=%b done=%b err=%b required count=%h run=%b done=%b err=%b",
                   a[10:3], a[2], a[1], a[0], e[10:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // Drive one cycle of commands and record the status expected after the edge
  task automatic step(input logic st, input logic sp, input logic cl, input logic tk,
                      input logic md, input logic [7:0] tg,
                      input logic [7:0] ec, input logic er, input logic ed, input logic ee);
    @(negedge clk);
    bus.start  = st;
    bus.stop   = sp;
    bus.clear  = cl;
    bus.tick   = tk;
    bus.mode   = md;
    bus.target = tg;
    q_exp.push_back({ec, er, ed, ee});
  endtask

  task automatic check_now(input string name, input logic [7:0] ec, input logic er,
                           input logic ed, input logic ee);
    total++;
    if ({bus.count, bus.running, bus.done, bus.err} !== {ec, er, ed, ee}) begin
      bad++;
      $display("FAIL %s: actual count=%h run=%b done=%b err=%b required count=%h run=%b done=%b err=%b",
               name, bus.count, bus.running, bus.done, bus.err, ec, er, ed, ee);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.clear  = 1'b0;
    bus.tick   = 1'b0;
    bus.mode   = 1'b0;
    bus.target = 8'h00;
    #23;
    check_now("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot with a BCD carry: target 12
    step(1, 0, 0, 0, 0, 8'h12, 8'h00, 1, 0, 0);
    for (int i = 1; i <= 12; i++)
      step(0, 0, 0, 1, 0, 8'h00, to_bcd(i), (i < 12), (i == 12), 0);
    step(0, 0, 0, 1, 0, 8'h00, 8'h12, 0, 0, 0);
    step(0, 1, 0, 1, 0, 8'h00, 8'h12, 0, 0, 0);

    // Auto-reload from DONE: target 03, done every third tick
    step(1, 0, 0, 0, 1, 8'h03, 8'h00, 1, 0, 0);
    for (int i = 1; i <= 7; i++)
      step(0, 0, 0, 1, 0, 8'h00, to_bcd(i % 3), 1, (i % 3 == 0), 0);

    // Pause / resume: target 20
    step(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 0, 8'h20, 8'h00, 1, 0, 0);
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, 1, 0, 8'h00, to_bcd(i), 1, 0, 0);
    step(0, 1, 0, 1, 0, 8'h00, 8'h05, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 1, 0, 8'h00, 8'h05, 0, 0, 0);
    // Resume with a different target on the bus: must not relatch
    step(1, 0, 0, 0, 1, 8'h07, 8'h05, 1, 0, 0);
    for (int i = 1; i <= 15; i++)
      step(0, 0, 0, 1, 0, 8'h00, to_bcd(5 + i), (i < 15), (i == 15), 0);

    // Invalid targets: non-decimal nibble, then zero; then a valid one
    step(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 0, 8'h1A, 8'h00, 0, 0, 1);
    step(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1);
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    step(1, 0, 0, 0, 0, 8'h05, 8'h00, 1, 0, 0);

    // Clear beats start and tick in the same cycle
    step(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 0, 8'h20, 8'h00, 1, 0, 0);
    for (int i = 1; i <= 7; i++)
      step(0, 0, 0, 1, 0, 8'h00, to_bcd(i), 1, 0, 0);
    step(1, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    step(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);

    // Auto-reload with target 01: continuous done on back-to-back ticks
    step(1, 0, 0, 0, 1, 8'h01, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 0);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);

    // Full 99 range: 98 ticks then terminal tick at target 99
    step(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 0, 8'h99, 8'h00, 1, 0, 0);
    for (int i = 1; i <= 99; i++)
      step(0, 0, 0, 1, 0, 8'h00, to_bcd(i), (i < 99), (i == 99), 0);

    // Asynchronous reset in the middle of a run
    step(1, 0, 0, 0, 0, 8'h20, 8'h00, 1, 0, 0);
    for (int i = 1; i <= 3; i++)
      step(0, 0, 0, 1, 0, 8'h00, to_bcd(i), 1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && q_exp.size() > 0; i++)
      @(posedge clk);
    #2;
    if (q_exp.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: actual pending=%0d required pending=0", q_exp.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_interval_ctrl.md
# bcd_interval_ctrl

Sequencing controller for a cascade of synchronous BCD digit counters. It accepts start/stop/clear commands and a BCD terminal value, and gates a count-enable tick into the digit chain. It signals completion either once (one-shot) or periodically (auto-reload). It sits between control logic and the BCD counter datapath, owning the run/pause/terminal-count sequencing that the bare counters lack.

## Interface
- DIGITS, default 2: number of BCD digits; count/target width is 4*DIGITS.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; forces all state and outputs to reset values immediately.
- start  input  1  begin a run (from IDLE/DONE) or resume (from PAUSE).
- stop  input  1  pause a running count.
- clear  input  1  synchronous abort to IDLE.
- mode  input  1  0 = one-shot, 1 = auto-reload; latched on start from IDLE/DONE.
- target  input  4*DIGITS  BCD terminal value; latched on start from IDLE/DONE.
- tick  input  1  count-enable strobe, one increment per sampled high cycle.
- count  output  4*DIGITS  current BCD count, digit 0 in [3:0].
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse on terminal count.
- err  output  1  sticky flag: start rejected because of an invalid target.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE with count=0, running=0, done=0, err=0, latched target=0, latched mode=0.
- A target is valid when every nibble is ≤ 9 and the value is nonzero.
- Command priority within a cycle: clear > stop > start > tick.
- IDLE:
  - start with a valid target: latch target/mode, count=0, err=0, go to RUN.
  - start with an invalid target: err=1, stay in IDLE.
  - tick is ignored.
- RUN:
  - tick increments count in BCD. A digit at 9 goes to 0 and carries into the next digit. The carry chain ripples across all digits in one cycle.
  - Terminal tick is a tick sampled while count == target-1 (BCD).
    - mode 0: count goes to target, done=1, go to DONE.
    - mode 1: count goes to 0, done=1, stay in RUN.
  - stop: go to PAUSE; a tick in the same cycle is dropped.
  - start is ignored.
- PAUSE:
  - count is held and tick is ignored.
  - start resumes RUN without relatching target or mode.
- DONE:
  - count is held at target and running=0.
  - start behaves as start from IDLE: relatch, count=0, validity check.
  - stop is ignored.
- clear in any state: IDLE, count=0, err=0, done=0.
- count never exceeds the latched target; the all-9s value wraps to 0 only through the reload path.

## Timing
- All outputs are registered and update on the rising edge after the sampled input.
- start sampled at edge N (from IDLE): running=1 and count=0 after edge N. The first tick counted is the one sampled at edge N+1.
- Count latency is one cycle: a tick sampled at edge N is reflected in count after edge N.
- done is high for exactly the one cycle following the terminal-tick edge. In mode 1, done pulses once per period; back-to-back ticks with target=1 give continuous done.
- err asserts the cycle after a rejected start. It clears only on clear, on an accepted start, or on reset.
- Asynchronous reset mid-run returns all outputs to reset values without waiting for clk. Operation resumes on the first rising edge after reset deasserts.

## Test plan
- Reset behaviour: assert reset mid-RUN at a non-edge time -> count=00, running=0, done=0, err=0 immediately; IDLE afterwards.
- One-shot with BCD carry: target=8'h12, mode=0, start, then 12 ticks -> count steps 00..09, 10, 11, 12. done pulses once with count=12, then DONE with running=0. Further ticks leave count at 12.
- Auto-reload: target=8'h03, mode=1, 7 ticks -> count 01, 02, 00, 01, 02, 00, 01. done pulses on ticks 3 and 6; running stays 1.
- Pause/resume: target=8'h20. After 5 ticks, stop together with a tick -> count holds 05 through 4 idle ticks. Then start, 15 ticks -> count=20, done pulse.
- Invalid target: start with 8'h1A, then with 8'h00 -> err=1, state IDLE, count=00. Then start with 8'h05 -> err=0, running=1.
- Clear priority: during RUN at count 07, assert clear, start and tick in the same cycle -> IDLE, count=00, running=0, no done.
